// File: rtl/rf_pkg.sv
// rf_pkg: constants and types shared by the multi-port register file.
//   XLEN_DEF   default data width
//   NREGS_DEF  default architectural register count
//   REG_ZERO   index of the hardwired-zero register
//   rf_addr_t  register address for the default register count
package rf_pkg;
  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int REG_ZERO  = 0;

  typedef logic [$clog2(NREGS_DEF)-1:0] rf_addr_t;
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: one busy bit per architectural register plus the registered
// all_idle flag.
// Ports:
//   CLK, Reset   clock, synchronous active-high reset
//   i_set_en     reserve a destination
//   i_set_addr   destination being reserved (address 0 ignored)
//   i_clr        one-hot-or-more vector of registers being written this cycle
//   o_busy       current busy vector
//   o_all_idle   registered: 1 when the busy vector was all zero before this edge
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter  int NREGS = NREGS_DEF,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             i_set_en,
  input  logic [AW-1:0]    i_set_addr,
  input  logic [NREGS-1:0] i_clr,
  output logic [NREGS-1:0] o_busy,
  output logic             o_all_idle
);

  logic [NREGS-1:0] r_busy;
  logic             r_all_idle;
  logic [NREGS-1:0] w_set;

  always_comb begin
    w_set = '0;
    if (i_set_en && (i_set_addr != AW'(REG_ZERO)))
      w_set[i_set_addr] = 1'b1;
  end

  // A reservation issued in the same cycle as a clearing write belongs to a
  // newer producer, so set is applied after clear.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_busy     <= '0;
      r_all_idle <= 1'b1;
    end else begin
      r_busy     <= (r_busy & ~i_clr) | w_set;
      r_all_idle <= ~|r_busy;
    end
  end

  assign o_busy     = r_busy;
  assign o_all_idle = r_all_idle;

endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: parameterised multi-port integer register file with a
// per-register busy scoreboard. Register 0 reads zero and is never busy.
// Optional feature macro: RF_BYPASS_EN (same-cycle write-to-read forwarding
// of data and busy-clear).
// Ports:
//   CLK, Reset  clock, synchronous active-high reset
//   rd_addr     NRD packed read addresses, port k at [k*AW +: AW]
//   rd_data     NRD packed read data, port k at [k*XLEN +: XLEN]
//   rd_busy     per read port: addressed register has a pending write
//   wr_en       per write port enable
//   wr_addr     NWR packed write addresses
//   wr_data     NWR packed write data
//   rsv_en      reserve destination rsv_addr (mark busy)
//   rsv_addr    destination being reserved
//   all_idle    registered: no register busy after the previous edge
module reg_file_mp
  import rf_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEF,
  parameter  int NREGS = NREGS_DEF,
  parameter  int NRD   = 2,
  parameter  int NWR   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [AW-1:0]     rsv_addr,
  output logic              all_idle
);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] w_clr;
  logic [NREGS-1:0] w_busy;

  always_comb begin
    w_clr = '0;
    for (int j = 0; j < NWR; j++) begin
      if (wr_en[j] && (wr_addr[j*AW +: AW] != AW'(REG_ZERO)))
        w_clr[wr_addr[j*AW +: AW]] = 1'b1;
    end
  end

  // Later loop iterations override earlier ones, so the highest-index port
  // wins a same-address collision. Register 0 is never written.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      for (int i = 0; i < NREGS; i++)
        r_regs[i] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && (wr_addr[j*AW +: AW] != AW'(REG_ZERO)))
          r_regs[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
      end
    end
  end

  rf_scoreboard #(
    .NREGS (NREGS)
  ) u_scoreboard (
    .CLK        (CLK),
    .Reset      (Reset),
    .i_set_en   (rsv_en),
    .i_set_addr (rsv_addr),
    .i_clr      (w_clr),
    .o_busy     (w_busy),
    .o_all_idle (all_idle)
  );

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] w_ra;
    assign w_ra = rd_addr[k*AW +: AW];

`ifdef RF_BYPASS_EN
    logic            w_hit;
    logic [XLEN-1:0] w_fwd;

    always_comb begin
      w_hit = 1'b0;
      w_fwd = '0;
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && (wr_addr[j*AW +: AW] == w_ra) && (w_ra != AW'(REG_ZERO))) begin
          w_hit = 1'b1;
          w_fwd = wr_data[j*XLEN +: XLEN];
        end
      end
    end

    assign rd_data[k*XLEN +: XLEN] = w_hit ? w_fwd : r_regs[w_ra];
    // A same-cycle reservation of the forwarded address keeps it busy.
    assign rd_busy[k] = w_busy[w_ra] & ~(w_hit & ~(rsv_en & (rsv_addr == w_ra)));
`else
    assign rd_data[k*XLEN +: XLEN] = r_regs[w_ra];
    assign rd_busy[k]              = w_busy[w_ra];
`endif
  end

endmodule
